fsm610_run_logger: RTL and testbench

Downstream consumer of the FSM610 equality-sequence detector's `z` output. It measures each contiguous run of `z`-high cycles (run length in clock cycles) and queues completed run lengths in a small show-ahead FIFO for a valid/ready reader. It also keeps a saturating count of completed runs and a sticky overflow flag for dropped records.

---
 rtl/fsm610_run_logger_if.sv | 25 ++
 rtl/fsm610_run_logger.sv | 121 ++++++++++++
 tb/tb_fsm610_run_logger.sv | 232 +++++++++++++++++++++++
 3 files changed

// File: rtl/fsm610_run_logger_if.sv
// Bus between the FSM610 run logger and its environment: detector input,
// clear, and the valid/ready record read port with status outputs.
interface fsm610_run_logger_if #(
  parameter int unsigned LEN_W = 8
);
  logic             z;
  logic             clear;
  logic             rd_ready;
  logic             rd_valid;
  logic [LEN_W-1:0] rd_data;
  logic             overflow;
  logic [7:0]       run_cnt;

  // Environment side: drives detector/clear/ready, observes the logger.
  modport master (
    output z, clear, rd_ready,
    input  rd_valid, rd_data, overflow, run_cnt
  );

  // Logger side.
  modport slave (
    input  z, clear, rd_ready,
    output rd_valid, rd_data, overflow, run_cnt
  );
endinterface

// File: rtl/fsm610_run_logger.sv
// Measures each contiguous run of z-high cycles and queues the completed
// run lengths in a show-ahead FIFO. Keeps a saturating completed-run count
// and a sticky flag for records dropped on a full FIFO.
module fsm610_run_logger #(
  parameter int unsigned LEN_W = 8,
  parameter int unsigned DEPTH = 4  // power of 2, >= 2
) (
  input  logic                Clock,
  input  logic                Reset,
  fsm610_run_logger_if.slave  bus
);

  localparam int unsigned     PtrW    = $clog2(DEPTH);
  localparam logic [LEN_W-1:0] LenMax = '1;
  localparam logic [PtrW:0]   CntFull = (PtrW + 1)'(DEPTH);

  typedef enum logic {StIdle, StRun} state_e;

  state_e           state_q, state_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic [7:0]       run_cnt_q, run_cnt_d;
  logic             overflow_q, overflow_d;
  logic [PtrW-1:0]  wptr_q, wptr_d;
  logic [PtrW-1:0]  rptr_q, rptr_d;
  logic [PtrW:0]    count_q, count_d;
  logic [LEN_W-1:0] mem_q [DEPTH];

  logic push;   // a run completes this cycle
  logic pop;    // reader takes the head record
  logic wr_en;  // completed record is actually stored

  // Next-state for the run FSM, counters and FIFO bookkeeping.
  always_comb begin
    state_d    = state_q;
    len_d      = len_q;
    run_cnt_d  = run_cnt_q;
    overflow_d = overflow_q;
    wptr_d     = wptr_q;
    rptr_d     = rptr_q;
    count_d    = count_q;
    push       = 1'b0;
    pop        = (count_q != '0) && bus.rd_ready;
    wr_en      = 1'b0;

    if (bus.clear) begin
      // Clear overrides everything, including a z=1 sample this cycle.
      state_d    = StIdle;
      len_d      = '0;
      run_cnt_d  = '0;
      overflow_d = 1'b0;
      wptr_d     = '0;
      rptr_d     = '0;
      count_d    = '0;
      pop        = 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (bus.z) begin
            state_d = StRun;
            len_d   = LEN_W'(1);
          end
        end
        StRun: begin
          if (bus.z) begin
            if (len_q != LenMax) len_d = len_q + 1'b1;
          end else begin
            push    = 1'b1;
            state_d = StIdle;
            len_d   = '0;
            if (run_cnt_q != 8'hFF) run_cnt_d = run_cnt_q + 8'd1;
          end
        end
        default: state_d = StIdle;
      endcase

      // A simultaneous pop frees the slot, so a full FIFO still accepts.
      wr_en = push && ((count_q != CntFull) || pop);
      if (push && !wr_en) overflow_d = 1'b1;
      if (wr_en) wptr_d = wptr_q + 1'b1;
      if (pop)   rptr_d = rptr_q + 1'b1;

      case ({wr_en, pop})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
    end
  end

  // State, counters and pointers with asynchronous reset.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state_q    <= StIdle;
      len_q      <= '0;
      run_cnt_q  <= '0;
      overflow_q <= 1'b0;
      wptr_q     <= '0;
      rptr_q     <= '0;
      count_q    <= '0;
    end else begin
      state_q    <= state_d;
      len_q      <= len_d;
      run_cnt_q  <= run_cnt_d;
      overflow_q <= overflow_d;
      wptr_q     <= wptr_d;
      rptr_q     <= rptr_d;
      count_q    <= count_d;
    end
  end

  // Record storage; contents are don't-care while the occupancy is zero.
  always_ff @(posedge Clock) begin
    if (wr_en) mem_q[wptr_q] <= len_q;
  end

  assign bus.rd_valid = (count_q != '0);
  assign bus.rd_data  = (count_q != '0) ? mem_q[rptr_q] : '0;
  assign bus.overflow = overflow_q;
  assign bus.run_cnt  = run_cnt_q;

endmodule

// File: tb/tb_fsm610_run_logger.sv
// Self-checking bench for fsm610_run_logger: constant vector table, directed
// corner sequences and randomized traffic against a queue-based model.
module tb_fsm610_run_logger;

  localparam int unsigned LEN_W   = 8;
  localparam int unsigned DEPTH   = 4;
  localparam int          LEN_MAX = (1 << LEN_W) - 1;

  logic Clock = 1'b0;
  logic Reset = 1'b1;

  fsm610_run_logger_if #(.LEN_W(LEN_W)) bus ();

  fsm610_run_logger #(.LEN_W(LEN_W), .DEPTH(DEPTH)) dut (
    .Clock (Clock),
    .Reset (Reset),
    .bus   (bus)
  );

  always #5 Clock = ~Clock;

  int checks = 0;
  int errors = 0;

  // Reference model: a queue of completed lengths plus an unbounded run length.
  int mq[$];
  int m_len = 0;
  int m_cnt = 0;
  bit m_ovf = 1'b0;

  typedef struct {
    bit z;
    bit clr;
    bit rdy;
    bit v;
    int d;
    bit o;
    int c;
  } vec_t;

  vec_t tbl[10];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic void model_clear();
    mq.delete();
    m_len = 0;
    m_cnt = 0;
    m_ovf = 1'b0;
  endfunction

  function automatic void model_step(input bit z, input bit clr, input bit rdy);
    bit pop;
    bit done;
    bit accept;
    if (clr) begin
      model_clear();
      return;
    end
    pop    = (mq.size() > 0) && rdy;
    done   = !z && (m_len > 0);
    accept = (mq.size() < DEPTH) || pop;
    if (done) m_cnt = (m_cnt < 255) ? m_cnt + 1 : 255;
    if (pop) void'(mq.pop_front());
    if (done) begin
      if (accept) mq.push_back((m_len > LEN_MAX) ? LEN_MAX : m_len);
      else        m_ovf = 1'b1;
    end
    m_len = z ? m_len + 1 : 0;
  endfunction

  task automatic compare_model();
    chk("rd_valid", int'(bus.rd_valid), (mq.size() > 0) ? 1 : 0);
    chk("rd_data", int'(bus.rd_data), (mq.size() > 0) ? mq[0] : 0);
    chk("overflow", int'(bus.overflow), int'(m_ovf));
    chk("run_cnt", int'(bus.run_cnt), m_cnt);
  endtask

  // One clock: drive inputs, step the model at the edge, compare 1 ns later.
  task automatic cyc(input bit z, input bit clr, input bit rdy);
    bus.z        = z;
    bus.clear    = clr;
    bus.rd_ready = rdy;
    @(posedge Clock);
    model_step(z, clr, rdy);
    #1;
    compare_model();
  endtask

  // Run of length len (ready low), ended by a z=0 cycle with ready=rdy_end.
  task automatic run(input int len, input bit rdy_end);
    for (int i = 0; i < len; i++) cyc(1'b1, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, rdy_end);
  endtask

  initial begin
    #10_000_000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    int exp_rd[4];

    tbl[0] = '{z:1, clr:0, rdy:0, v:0, d:0, o:0, c:0};
    tbl[1] = '{z:1, clr:0, rdy:0, v:0, d:0, o:0, c:0};
    tbl[2] = '{z:1, clr:0, rdy:0, v:0, d:0, o:0, c:0};
    tbl[3] = '{z:0, clr:0, rdy:0, v:1, d:3, o:0, c:1};
    tbl[4] = '{z:0, clr:0, rdy:1, v:0, d:0, o:0, c:1};
    tbl[5] = '{z:1, clr:0, rdy:1, v:0, d:0, o:0, c:1};
    tbl[6] = '{z:0, clr:0, rdy:1, v:1, d:1, o:0, c:2};
    tbl[7] = '{z:0, clr:0, rdy:0, v:1, d:1, o:0, c:2};
    tbl[8] = '{z:0, clr:0, rdy:1, v:0, d:0, o:0, c:2};
    tbl[9] = '{z:0, clr:0, rdy:1, v:0, d:0, o:0, c:2};

    bus.z        = 1'b0;
    bus.clear    = 1'b0;
    bus.rd_ready = 1'b0;
    #1;
    chk("reset_valid", int'(bus.rd_valid), 0);
    chk("reset_data", int'(bus.rd_data), 0);
    chk("reset_ovf", int'(bus.overflow), 0);
    chk("reset_cnt", int'(bus.run_cnt), 0);
    #20;
    Reset = 1'b0;
    model_clear();

    // Single run, pop, push into empty with ready high, ready while empty.
    for (int i = 0; i < 10; i++) begin
      cyc(tbl[i].z, tbl[i].clr, tbl[i].rdy);
      chk($sformatf("tbl%0d_valid", i), int'(bus.rd_valid), int'(tbl[i].v));
      chk($sformatf("tbl%0d_data", i), int'(bus.rd_data), tbl[i].d);
      chk($sformatf("tbl%0d_ovf", i), int'(bus.overflow), int'(tbl[i].o));
      chk($sformatf("tbl%0d_cnt", i), int'(bus.run_cnt), tbl[i].c);
    end

    // Asynchronous reset mid-run with a record queued.
    run(2, 1'b0);
    cyc(1'b1, 1'b0, 1'b0);
    cyc(1'b1, 1'b0, 1'b0);
    #2;
    Reset = 1'b1;
    #1;
    model_clear();
    chk("areset_valid", int'(bus.rd_valid), 0);
    chk("areset_data", int'(bus.rd_data), 0);
    chk("areset_cnt", int'(bus.run_cnt), 0);
    @(posedge Clock);
    #1;
    Reset = 1'b0;
    cyc(1'b0, 1'b0, 1'b0);
    chk("post_reset_valid", int'(bus.rd_valid), 0);
    chk("post_reset_cnt", int'(bus.run_cnt), 0);

    // Length saturation.
    cyc(1'b0, 1'b1, 1'b0);
    run(300, 1'b0);
    chk("sat_len", int'(bus.rd_data), 255);

    // Run count saturation.
    cyc(1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 260; i++) begin
      cyc(1'b1, 1'b0, 1'b1);
      cyc(1'b0, 1'b0, 1'b1);
    end
    chk("sat_cnt", int'(bus.run_cnt), 255);

    // Overflow: five runs into a four-entry FIFO, then drain.
    cyc(1'b0, 1'b1, 1'b0);
    for (int l = 1; l <= 5; l++) run(l, 1'b0);
    chk("ovf_flag", int'(bus.overflow), 1);
    chk("ovf_cnt", int'(bus.run_cnt), 5);
    for (int i = 0; i < 4; i++) begin
      chk("ovf_drain", int'(bus.rd_data), i + 1);
      cyc(1'b0, 1'b0, 1'b1);
    end
    chk("ovf_empty", int'(bus.rd_valid), 0);
    chk("ovf_sticky", int'(bus.overflow), 1);

    // Full FIFO with a pop on the completing edge.
    cyc(1'b0, 1'b1, 1'b0);
    for (int l = 1; l <= 4; l++) run(l, 1'b0);
    run(7, 1'b1);
    chk("fullpop_ovf", int'(bus.overflow), 0);
    exp_rd = '{2, 3, 4, 7};
    for (int i = 0; i < 4; i++) begin
      chk("fullpop_drain", int'(bus.rd_data), exp_rd[i]);
      cyc(1'b0, 1'b0, 1'b1);
    end
    chk("fullpop_empty", int'(bus.rd_valid), 0);

    // Pointer wrap: ten records through the FIFO, order preserved.
    cyc(1'b0, 1'b1, 1'b0);
    for (int k = 0; k < 5; k++) begin
      run(2 * k + 1, 1'b0);
      run(2 * k + 2, 1'b0);
      chk("wrap_a", int'(bus.rd_data), 2 * k + 1);
      cyc(1'b0, 1'b0, 1'b1);
      chk("wrap_b", int'(bus.rd_data), 2 * k + 2);
      cyc(1'b0, 1'b0, 1'b1);
    end

    // Clear with two entries queued, overflow set and z=1 in the clear cycle.
    for (int l = 1; l <= 5; l++) run(l, 1'b0);
    cyc(1'b0, 1'b0, 1'b1);
    cyc(1'b0, 1'b0, 1'b1);
    chk("preclr_valid", int'(bus.rd_valid), 1);
    cyc(1'b1, 1'b1, 1'b0);
    chk("clr_valid", int'(bus.rd_valid), 0);
    chk("clr_ovf", int'(bus.overflow), 0);
    chk("clr_cnt", int'(bus.run_cnt), 0);
    cyc(1'b0, 1'b0, 1'b0);
    chk("clr_norun", int'(bus.rd_valid), 0);
    chk("clr_norun_cnt", int'(bus.run_cnt), 0);

    // Randomized traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      cyc($urandom_range(0, 99) < 60, $urandom_range(0, 199) == 0,
          $urandom_range(0, 99) < 30);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
